// File: rtl/apb_mailbox.sv
// rtl/apb_mailbox.sv - APB3 mailbox with TX and RX word FIFOs between software and a stream
//
// Purpose: software pushes words into the TX FIFO through TXDATA and they leave on the
// tx stream; words arriving on the rx stream queue in the RX FIFO and are popped by
// reading RXDATA. A TXDATA write to a full TX FIFO either errors at once or, with
// CTRL.tx_block set, stalls the bus until space appears or TIMEOUT cycles pass.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   psel, penable, pwrite         APB control; access phase is psel & penable
//   paddr, pwdata                 APB byte address (bits [1:0] ignored) and write data
//   prdata, pready, pslverr       APB response, combinational during the access phase
//   tx_valid, tx_data, tx_ready   TX stream out (first-word-fall-through head)
//   rx_valid, rx_data, rx_ready   RX stream in
module apb_mailbox #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int DEPTH          = 8,
   parameter int TIMEOUT        = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [APB_ADDR_WIDTH-1:0] paddr,
   input  logic [31:0]               pwdata,
   output logic [31:0]               prdata,
   output logic                      pready,
   output logic                      pslverr,
   output logic                      tx_valid,
   output logic [31:0]               tx_data,
   input  logic                      tx_ready,
   input  logic                      rx_valid,
   input  logic [31:0]               rx_data,
   output logic                      rx_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = APB_ADDR_WIDTH - 2;

   localparam logic [WW-1:0] OFF_TX   = WW'(0);
   localparam logic [WW-1:0] OFF_RX   = WW'(1);
   localparam logic [WW-1:0] OFF_ST   = WW'(2);
   localparam logic [WW-1:0] OFF_CT   = WW'(3);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [15:0]   STALL_MAX = 16'(TIMEOUT);

   logic [31:0]   tx_mem_q [DEPTH];
   logic [31:0]   tx_mem_d [DEPTH];
   logic [31:0]   rx_mem_q [DEPTH];
   logic [31:0]   rx_mem_d [DEPTH];
   logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic          tx_block_q, tx_block_d;
   logic          err_q, err_d;
   logic [15:0]   stall_q, stall_d;

   logic [WW-1:0] word;
   logic          access, done;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic          tx_push, tx_pop, rx_push, rx_pop;
   logic          ctrl_wr, tx_flush, rx_flush, err_clr;
   logic          unused_addr_lsbs;

   assign unused_addr_lsbs = ^paddr[1:0];

   always_comb begin
      word     = paddr[APB_ADDR_WIDTH-1:2];
      access   = psel & penable;
      tx_full  = (tx_cnt_q == FULL_CNT);
      tx_empty = (tx_cnt_q == '0);
      rx_full  = (rx_cnt_q == FULL_CNT);
      rx_empty = (rx_cnt_q == '0);

      prdata  = 32'h0;
      pready  = 1'b1;
      pslverr = 1'b0;
      if (access) begin
         case (word)
            OFF_TX: begin
               // Reads of TXDATA return 0 without error; only a full FIFO affects writes.
               if (pwrite && tx_full) begin
                  if (!tx_block_q)               pslverr = 1'b1;
                  else if (stall_q == STALL_MAX) pslverr = 1'b1;
                  else                           pready  = 1'b0;
               end
            end
            OFF_RX: begin
               if (pwrite || rx_empty) pslverr = 1'b1;
               else                    prdata  = rx_mem_q[rx_rp_q];
            end
            OFF_ST: begin
               if (pwrite) pslverr = 1'b1;
               else prdata = {13'h0, err_q, rx_empty, tx_full, 8'(rx_cnt_q), 8'(tx_cnt_q)};
            end
            OFF_CT: begin
               if (!pwrite) prdata = {23'h0, tx_block_q, 8'h0};
            end
            default: pslverr = 1'b1;
         endcase
      end

      done     = access & pready;
      tx_push  = done & (word == OFF_TX) & pwrite & ~pslverr;
      rx_pop   = done & (word == OFF_RX) & ~pwrite & ~pslverr;
      ctrl_wr  = done & (word == OFF_CT) & pwrite;
      tx_flush = ctrl_wr & pwdata[0];
      rx_flush = ctrl_wr & pwdata[1];
      err_clr  = ctrl_wr & pwdata[2];

      tx_valid = ~tx_empty;
      tx_data  = tx_mem_q[tx_rp_q];
      tx_pop   = tx_valid & tx_ready;
      rx_ready = ~rx_full;
      rx_push  = rx_valid & rx_ready;

      // The stall counter only runs while a blocking write is being held off.
      stall_d    = (access && !pready) ? stall_q + 16'd1 : 16'd0;
      tx_block_d = ctrl_wr ? pwdata[8] : tx_block_q;
      // A new error outranks a same-cycle clear.
      err_d      = (done && pslverr) ? 1'b1 : (err_clr ? 1'b0 : err_q);

      tx_mem_d = tx_mem_q;
      tx_wp_d  = tx_wp_q;
      tx_rp_d  = tx_rp_q;
      tx_cnt_d = tx_cnt_q;
      if (tx_push) begin
         tx_mem_d[tx_wp_q] = pwdata;
         tx_wp_d = tx_wp_q + PW'(1);
      end
      if (tx_pop) tx_rp_d = tx_rp_q + PW'(1);
      case ({tx_push, tx_pop})
         2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
         2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
         default: tx_cnt_d = tx_cnt_q;
      endcase
      if (tx_flush) begin
         tx_wp_d  = '0;
         tx_rp_d  = '0;
         tx_cnt_d = '0;
      end

      rx_mem_d = rx_mem_q;
      rx_wp_d  = rx_wp_q;
      rx_rp_d  = rx_rp_q;
      rx_cnt_d = rx_cnt_q;
      if (rx_push) begin
         rx_mem_d[rx_wp_q] = rx_data;
         rx_wp_d = rx_wp_q + PW'(1);
      end
      if (rx_pop) rx_rp_d = rx_rp_q + PW'(1);
      case ({rx_push, rx_pop})
         2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
         2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
         default: rx_cnt_d = rx_cnt_q;
      endcase
      if (rx_flush) begin
         rx_wp_d  = '0;
         rx_rp_d  = '0;
         rx_cnt_d = '0;
      end
   end

   // Storage needs no reset: the counts define which entries are live.
   always_ff @(posedge clk) begin
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wp_q    <= '0;
         tx_rp_q    <= '0;
         tx_cnt_q   <= '0;
         rx_wp_q    <= '0;
         rx_rp_q    <= '0;
         rx_cnt_q   <= '0;
         tx_block_q <= 1'b0;
         err_q      <= 1'b0;
         stall_q    <= 16'd0;
      end else begin
         tx_wp_q    <= tx_wp_d;
         tx_rp_q    <= tx_rp_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_wp_q    <= rx_wp_d;
         rx_rp_q    <= rx_rp_d;
         rx_cnt_q   <= rx_cnt_d;
         tx_block_q <= tx_block_d;
         err_q      <= err_d;
         stall_q    <= stall_d;
      end
   end

endmodule

// File: tb/tb_apb_mailbox.sv
// tb/tb_apb_mailbox.sv - directed self-checking bench for apb_mailbox
module tb_apb_mailbox;

   logic        clk;
   logic        rst;
   logic        psel, penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        tx_valid, tx_ready;
   logic [31:0] tx_data;
   logic        rx_valid, rx_ready;
   logic [31:0] rx_data;

   int checks   = 0;
   int failures = 0;

   apb_mailbox #(.APB_ADDR_WIDTH(12), .DEPTH(8), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One APB transfer; entered and left at posedge+1.
   task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err, output int waits);
      bit finished = 0;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      waits = 0;
      rd = 32'h0;
      err = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (pready === 1'b1) begin
            rd = prdata;
            err = pslverr;
            finished = 1;
            break;
         end
         waits++;
         @(posedge clk); #1;
      end
      checks++;
      if (!finished) begin
         failures++;
         $display("FAIL apb_timeout addr=%h: got no pready, expected completion", a);
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic er; int w;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({tx_valid, rx_ready, pready, pslverr} !== 4'b0110 || prdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs: got tv=%b rr=%b pr=%b err=%b prdata=%h, expected 0 1 1 0 0",
                  tx_valid, rx_ready, pready, pslverr, prdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      apb_xfer(1'b0, 12'h008, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0002_0000 || er !== 1'b0) begin
         failures++;
         $display("FAIL reset_status: got %h err=%b, expected 00020000 err=0", rd, er);
      end
   endtask

   task automatic test_tx_order();
      logic [31:0] rd; logic er; int w;
      logic [31:0] exp_w [3];
      exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33;
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) apb_xfer(1'b1, 12'h000, exp_w[i], rd, er, w);
      apb_xfer(1'b0, 12'h008, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0002_0003) begin
         failures++;
         $display("FAIL tx3_status: got %h, expected 00020003", rd);
      end
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 32'h11) begin
         failures++;
         $display("FAIL tx_head: got valid=%b data=%h, expected 1 00000011", tx_valid, tx_data);
      end
      @(posedge clk); #1;
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== exp_w[i]) begin
            failures++;
            $display("FAIL tx_order[%0d]: got valid=%b data=%h, expected 1 %h", i, tx_valid, tx_data, exp_w[i]);
         end
         @(posedge clk); #1;
      end
      tx_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL tx_drained: got valid=%b, expected 0", tx_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_tx_full_nonblock();
      logic [31:0] rd; logic er; int w;
      int errs = 0;
      for (int i = 0; i < 8; i++) begin
         apb_xfer(1'b1, 12'h000, 32'h100 + i, rd, er, w);
         if (er !== 1'b0 || w != 0) errs++;
      end
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL fill_writes: got %0d bad completions, expected 0", errs);
      end
      apb_xfer(1'b1, 12'h000, 32'h108, rd, er, w);
      checks++;
      if (er !== 1'b1 || w != 0) begin
         failures++;
         $display("FAIL full_nonblock: got err=%b waits=%0d, expected err=1 waits=0", er, w);
      end
      apb_xfer(1'b0, 12'h008, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0007_0008) begin
         failures++;
         $display("FAIL full_status: got %h, expected 00070008", rd);
      end
      apb_xfer(1'b1, 12'h00C, 32'h4, rd, er, w);
      apb_xfer(1'b0, 12'h008, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0003_0008) begin
         failures++;
         $display("FAIL err_clr_status: got %h, expected 00030008", rd);
      end
   endtask

   task automatic test_block_wait();
      logic [31:0] rd; logic er; int w;
      int waits = 0;
      logic got_err = 1'b1;
      bit finished = 0;
      apb_xfer(1'b1, 12'h00C, 32'h100, rd, er, w);
      apb_xfer(1'b0, 12'h00C, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0000_0100) begin
         failures++;
         $display("FAIL ctrl_readback: got %h, expected 00000100", rd);
      end
      // Blocking write with tx_ready pulsed in the sixth access cycle.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'hBEEF;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int k = 0; k < 50; k++) begin
         tx_ready = (k == 5);
         @(negedge clk);
         if (pready === 1'b1) begin
            got_err = pslverr;
            finished = 1;
            break;
         end
         waits++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_ready = 1'b0;
      checks++;
      if (!finished || waits != 6 || got_err !== 1'b0) begin
         failures++;
         $display("FAIL block_wait: got done=%0d waits=%0d err=%b, expected 1 6 0", finished, waits, got_err);
      end
      apb_xfer(1'b0, 12'h008, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0003_0008) begin
         failures++;
         $display("FAIL block_status: got %h, expected 00030008", rd);
      end
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [31:0] e;
         e = (i < 7) ? 32'h101 + i : 32'hBEEF;
         @(negedge clk);
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== e) begin
            failures++;
            $display("FAIL block_drain[%0d]: got valid=%b data=%h, expected 1 %h", i, tx_valid, tx_data, e);
         end
         @(posedge clk); #1;
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_block_timeout();
      logic [31:0] rd; logic er; int w;
      for (int i = 0; i < 8; i++) apb_xfer(1'b1, 12'h000, 32'h200 + i, rd, er, w);
      apb_xfer(1'b1, 12'h000, 32'hDEAD, rd, er, w);
      checks++;
      if (w != 255 || er !== 1'b1) begin
         failures++;
         $display("FAIL block_timeout: got waits=%0d err=%b, expected 255 1", w, er);
      end
      apb_xfer(1'b0, 12'h008, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0007_0008) begin
         failures++;
         $display("FAIL timeout_status: got %h, expected 00070008", rd);
      end
      apb_xfer(1'b1, 12'h00C, 32'h1, rd, er, w);
      apb_xfer(1'b0, 12'h008, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0006_0000 || tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL tx_flush: got status=%h tv=%b, expected 00060000 0", rd, tx_valid);
      end
      apb_xfer(1'b0, 12'h00C, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0) begin
         failures++;
         $display("FAIL ctrl_selfclear: got %h, expected 00000000", rd);
      end
      apb_xfer(1'b1, 12'h00C, 32'h4, rd, er, w);
   endtask

   task automatic test_rx();
      logic [31:0] rd; logic er; int w;
      logic [31:0] sim_rd; logic sim_err; logic sim_rdy;
      rx_valid = 1'b1; rx_data = 32'h1234_5678;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      apb_xfer(1'b0, 12'h008, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0000_0100) begin
         failures++;
         $display("FAIL rx1_status: got %h, expected 00000100", rd);
      end
      // RXDATA pop in the same cycle as an rx stream push.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
      @(posedge clk); #1;
      penable = 1'b1; rx_valid = 1'b1; rx_data = 32'hA5A5_0001;
      @(negedge clk);
      sim_rdy = pready; sim_rd = prdata; sim_err = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; rx_valid = 1'b0;
      checks++;
      if (sim_rdy !== 1'b1 || sim_rd !== 32'h1234_5678 || sim_err !== 1'b0) begin
         failures++;
         $display("FAIL rx_simul: got rdy=%b data=%h err=%b, expected 1 12345678 0", sim_rdy, sim_rd, sim_err);
      end
      apb_xfer(1'b0, 12'h008, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0000_0100) begin
         failures++;
         $display("FAIL rx_simul_count: got %h, expected 00000100", rd);
      end
      apb_xfer(1'b0, 12'h004, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'hA5A5_0001 || er !== 1'b0) begin
         failures++;
         $display("FAIL rx_second: got %h err=%b, expected a5a50001 0", rd, er);
      end
      apb_xfer(1'b0, 12'h004, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0 || er !== 1'b1) begin
         failures++;
         $display("FAIL rx_empty_read: got %h err=%b, expected 00000000 1", rd, er);
      end
      apb_xfer(1'b0, 12'h010, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0 || er !== 1'b1) begin
         failures++;
         $display("FAIL unmapped: got %h err=%b, expected 00000000 1", rd, er);
      end
      apb_xfer(1'b1, 12'h008, 32'hFFFF_FFFF, rd, er, w);
      checks++;
      if (er !== 1'b1) begin
         failures++;
         $display("FAIL status_write: got err=%b, expected 1", er);
      end
      apb_xfer(1'b0, 12'h008, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0006_0000) begin
         failures++;
         $display("FAIL rx_err_status: got %h, expected 00060000", rd);
      end
      apb_xfer(1'b1, 12'h00C, 32'h4, rd, er, w);
      // Nine offered words: the ninth must be refused by rx_ready.
      for (int i = 0; i < 9; i++) begin
         rx_valid = 1'b1; rx_data = 32'h300 + i;
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b0) begin
         failures++;
         $display("FAIL rx_full_ready: got %b, expected 0", rx_ready);
      end
      @(posedge clk); #1;
      apb_xfer(1'b0, 12'h008, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0000_0800) begin
         failures++;
         $display("FAIL rx_full_status: got %h, expected 00000800", rd);
      end
      apb_xfer(1'b0, 12'h004, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0000_0300 || er !== 1'b0) begin
         failures++;
         $display("FAIL rx_full_head: got %h err=%b, expected 00000300 0", rd, er);
      end
      apb_xfer(1'b1, 12'h00C, 32'h2, rd, er, w);
      apb_xfer(1'b0, 12'h008, 32'h0, rd, er, w);
      checks++;
      if (rd !== 32'h0002_0000 || rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL rx_flush: got %h rr=%b, expected 00020000 1", rd, rx_ready);
      end
   endtask

   initial begin
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 12'h0; pwdata = 32'h0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 32'h0;
      test_reset();
      test_tx_order();
      test_tx_full_nonblock();
      test_block_wait();
      test_block_timeout();
      test_rx();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
